// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction type codes, per-type predicates,
// forwarding select encodings and the micro-op summary payload.
package pipe_pkg;

  localparam int unsigned INS_W = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  typedef enum logic [INS_W-1:0] {
    INS_BUBBLE = 6'd0,
    INS_ALU    = 6'd1,
    INS_LW     = 6'd2,
    INS_SW     = 6'd3,
    INS_DIV    = 6'd4,
    INS_DIVU   = 6'd5,
    INS_MFHI   = 6'd6,
    INS_MFLO   = 6'd7,
    INS_BEQ    = 6'd8
  } ins_type_e;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Summary of one in-flight micro-op as carried by the transfer line
  typedef struct packed {
    logic [INS_W-1:0] ins_type;
    logic [REG_W-1:0] wb_dest;
  } uop_sum_t;

  function automatic logic writes_reg(input logic [INS_W-1:0] t);
    return t inside {INS_ALU, INS_LW, INS_MFHI, INS_MFLO};
  endfunction

  function automatic logic is_load(input logic [INS_W-1:0] t);
    return t == INS_LW;
  endfunction

  function automatic logic is_div(input logic [INS_W-1:0] t);
    return t inside {INS_DIV, INS_DIVU};
  endfunction

  function automatic logic reads_hilo(input logic [INS_W-1:0] t);
    return t inside {INS_MFHI, INS_MFLO};
  endfunction

  // A stage produces a forwardable register result
  function automatic logic producer_valid(input uop_sum_t u);
    return (u.ins_type != INS_BUBBLE) && writes_reg(u.ins_type) && (u.wb_dest != '0);
  endfunction

endpackage

// File: rtl/div_sequencer.sv
// Multi-cycle divider sequencer: launch -> DIV_LAT busy cycles -> one done cycle.
module div_sequencer
  import pipe_pkg::*;
#(
  parameter int unsigned DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(DIV_LAT);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DIV_LAT - 1);

  div_state_e       state;
  logic [CNT_W-1:0] count;

  // busy/done are registered alongside the state they decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start) begin
            state <= DIV_BUSY;
            count <= LOAD;
            busy  <= 1'b1;
          end
        end
        DIV_BUSY: begin
          if (count == '0) begin
            state <= DIV_DONE;
            done  <= 1'b1;
          end else begin
            count <= count - 1'b1;
            busy  <= 1'b1;
          end
        end
        DIV_DONE: begin
          if (start) begin
            state <= DIV_BUSY;
            count <= LOAD;
            busy  <= 1'b1;
          end else begin
            state <= DIV_IDLE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use and HI/LO interlocks, operand forwarding
// selects, divider launch and a saturating stall-cycle counter.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [INS_W-1:0] id_insType,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [INS_W-1:0] EX_insType,
  input  logic [INS_W-1:0] MEM_insType,
  input  logic [REG_W-1:0] EX_WBDest,
  input  logic [REG_W-1:0] MEM_WBDest,
  output logic             stall,
  output logic [FWD_W-1:0] fwd_rs,
  output logic [FWD_W-1:0] fwd_rt,
  output logic             div_start,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cycles
);

  uop_sum_t ex_sum;
  uop_sum_t mem_sum;
  logic     ex_prod;
  logic     mem_prod;
  logic     ex_load;
  logic     load_use_rs;
  logic     load_use_rt;
  logic     hilo_wait;
  logic     div_wait;
  logic     stall_raw;

  assign ex_sum   = '{ins_type: EX_insType,  wb_dest: EX_WBDest};
  assign mem_sum  = '{ins_type: MEM_insType, wb_dest: MEM_WBDest};
  assign ex_prod  = producer_valid(ex_sum);
  assign mem_prod = producer_valid(mem_sum);
  assign ex_load  = is_load(EX_insType);

  // A load still in EX has no result yet, so it shadows any older MEM match
  function automatic logic [FWD_W-1:0] pick_src(input logic rd_en,
                                                input logic [REG_W-1:0] src,
                                                input logic ex_ok,
                                                input logic ex_ld,
                                                input logic [REG_W-1:0] ex_dst,
                                                input logic mem_ok,
                                                input logic [REG_W-1:0] mem_dst);
    if (!rd_en)                     return FWD_RF;
    if (ex_ok && (ex_dst == src))   return ex_ld ? FWD_RF : FWD_EX;
    if (mem_ok && (mem_dst == src)) return FWD_MEM;
    return FWD_RF;
  endfunction

  assign load_use_rs = id_use_rs && ex_prod && ex_load && (EX_WBDest == id_rs);
  assign load_use_rt = id_use_rt && ex_prod && ex_load && (EX_WBDest == id_rt);
  assign hilo_wait   = reads_hilo(id_insType) && (div_busy || div_done);
  assign div_wait    = is_div(id_insType) && div_busy;
  assign stall_raw   = id_valid && (load_use_rs || load_use_rt || hilo_wait || div_wait);

  // Combinational outputs are held quiet while reset is asserted
  assign stall     = rst_n && stall_raw;
  assign div_start = rst_n && id_valid && is_div(id_insType) && !stall_raw;
  assign fwd_rs    = rst_n ? pick_src(id_use_rs, id_rs, ex_prod, ex_load, EX_WBDest,
                                      mem_prod, MEM_WBDest) : FWD_RF;
  assign fwd_rt    = rst_n ? pick_src(id_use_rt, id_rt, ex_prod, ex_load, EX_WBDest,
                                      mem_prod, MEM_WBDest) : FWD_RF;

  div_sequencer #(
    .DIV_LAT (DIV_LAT)
  ) u_div_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .busy  (div_busy),
    .done  (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios plus random traffic
// checked against a cycle-count reference model.
module tb_hazard_stall_ctrl;
  import pipe_pkg::*;

  localparam int unsigned DIV_LAT = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [5:0]       id_insType;
  logic [4:0]       id_rs, id_rt;
  logic             id_use_rs, id_use_rt;
  logic [5:0]       EX_insType, MEM_insType;
  logic [4:0]       EX_WBDest, MEM_WBDest;
  logic             stall;
  logic [1:0]       fwd_rs, fwd_rt;
  logic             div_start, div_busy, div_done;
  logic [CNT_W-1:0] stall_cycles;

  hazard_stall_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_insType   (id_insType),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .EX_insType   (EX_insType),
    .MEM_insType  (MEM_insType),
    .EX_WBDest    (EX_WBDest),
    .MEM_WBDest   (MEM_WBDest),
    .stall        (stall),
    .fwd_rs       (fwd_rs),
    .fwd_rt       (fwd_rt),
    .div_start    (div_start),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [5:0] ins;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt;
    logic [5:0] ex_ins, mem_ins;
    logic [4:0] ex_dest, mem_dest;
  } stim_t;

  typedef struct {
    logic             stall;
    logic [1:0]       fwd_rs, fwd_rt;
    logic             div_start, div_busy, div_done;
    logic [CNT_W-1:0] cyc;
    int               tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;
  int   since = 0;        // cycles since last divider launch, 0 = no divide in flight
  int   stall_total = 0;

  function automatic bit m_writes(input logic [5:0] t);
    case (t)
      INS_ALU, INS_LW, INS_MFHI, INS_MFLO: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] m_fwd(input logic rd, input logic [4:0] src, input stim_t s,
                                       input bit ex_ok, input bit mem_ok);
    if (!rd) return 2'b00;
    if (ex_ok && s.ex_dest == src) return (s.ex_ins == INS_LW) ? 2'b00 : 2'b01;
    if (mem_ok && s.mem_dest == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic exp_t model(input stim_t s, input logic rst);
    exp_t e;
    bit ex_ok, mem_ok, lu, busy, done, hilo, dv;
    e = '{stall: 1'b0, fwd_rs: 2'b00, fwd_rt: 2'b00, div_start: 1'b0,
          div_busy: 1'b0, div_done: 1'b0, cyc: '0, tag: 0};
    if (!rst) return e;
    ex_ok  = (s.ex_ins != 0) && m_writes(s.ex_ins) && (s.ex_dest != 0);
    mem_ok = (s.mem_ins != 0) && m_writes(s.mem_ins) && (s.mem_dest != 0);
    e.fwd_rs = m_fwd(s.use_rs, s.rs, s, ex_ok, mem_ok);
    e.fwd_rt = m_fwd(s.use_rt, s.rt, s, ex_ok, mem_ok);
    lu   = ex_ok && (s.ex_ins == INS_LW) &&
           ((s.use_rs && s.ex_dest == s.rs) || (s.use_rt && s.ex_dest == s.rt));
    busy = (since >= 1) && (since <= DIV_LAT);
    done = (since == DIV_LAT + 1);
    hilo = (s.ins == INS_MFHI) || (s.ins == INS_MFLO);
    dv   = (s.ins == INS_DIV) || (s.ins == INS_DIVU);
    e.stall     = s.valid && (lu || (hilo && (busy || done)) || (dv && busy));
    e.div_start = s.valid && dv && !e.stall;
    e.div_busy  = busy;
    e.div_done  = done;
    e.cyc       = CNT_W'((stall_total > CNT_MAX) ? CNT_MAX : stall_total);
    return e;
  endfunction

  // Drive one cycle of inputs mid-cycle, queue its expectation, advance the model
  task automatic step(input stim_t s, input logic rst);
    exp_t e;
    @(negedge clk);
    rst_n       = rst;
    id_valid    = s.valid;   id_insType  = s.ins;
    id_rs       = s.rs;      id_rt       = s.rt;
    id_use_rs   = s.use_rs;  id_use_rt   = s.use_rt;
    EX_insType  = s.ex_ins;  MEM_insType = s.mem_ins;
    EX_WBDest   = s.ex_dest; MEM_WBDest  = s.mem_dest;
    e = model(s, rst);
    e.tag = cyc_no;
    cyc_no++;
    sb.push_back(e);
    if (!rst) begin
      since = 0;
      stall_total = 0;
    end else begin
      if (e.stall) stall_total++;
      if (e.div_start) since = 1;
      else if (since >= 1 && since <= DIV_LAT) since++;
      else since = 0;
    end
  endtask

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, tag, act, req);
    end
  endtask

  // Monitor: compare every queued expectation against what the DUT presents
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall",        e.tag, 32'(stall),        32'(e.stall));
        chk("fwd_rs",       e.tag, 32'(fwd_rs),       32'(e.fwd_rs));
        chk("fwd_rt",       e.tag, 32'(fwd_rt),       32'(e.fwd_rt));
        chk("div_start",    e.tag, 32'(div_start),    32'(e.div_start));
        chk("div_busy",     e.tag, 32'(div_busy),     32'(e.div_busy));
        chk("div_done",     e.tag, 32'(div_done),     32'(e.div_done));
        chk("stall_cycles", e.tag, 32'(stall_cycles), 32'(e.cyc));
      end
    end
  end

  function automatic stim_t nop();
    stim_t s;
    s = '{valid: 1'b0, ins: 6'd0, rs: 5'd0, rt: 5'd0, use_rs: 1'b0, use_rt: 1'b0,
          ex_ins: 6'd0, mem_ins: 6'd0, ex_dest: 5'd0, mem_dest: 5'd0};
    return s;
  endfunction

  initial begin
    stim_t s, lu, dv, mf;
    rst_n = 1'b0;
    id_valid = 0; id_insType = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    EX_insType = 0; MEM_insType = 0; EX_WBDest = 0; MEM_WBDest = 0;

    lu = nop(); lu.valid = 1; lu.ins = INS_ALU; lu.rt = 5'd3; lu.use_rt = 1;
    lu.ex_ins = INS_LW; lu.ex_dest = 5'd3;
    dv = nop(); dv.valid = 1; dv.ins = INS_DIV; dv.rs = 5'd1; dv.rt = 5'd2;
    dv.use_rs = 1; dv.use_rt = 1;
    mf = nop(); mf.valid = 1; mf.ins = INS_MFHI; mf.ex_ins = INS_DIV;

    // Reset holds every output low even with a hazard presented
    repeat (3) step(lu, 1'b0);
    step(nop(), 1'b1);

    // Forwarding priority and producer qualification
    s = nop(); s.valid = 1; s.ins = INS_ALU; s.rs = 5'd5; s.use_rs = 1;
    s.ex_ins = INS_ALU; s.ex_dest = 5'd5; s.mem_ins = INS_ALU; s.mem_dest = 5'd5;
    step(s, 1'b1);
    s.ex_ins = INS_BUBBLE;                        step(s, 1'b1);
    s.mem_ins = INS_BUBBLE; s.ex_ins = INS_ALU; s.ex_dest = 5'd0; step(s, 1'b1);
    s.ex_ins = INS_SW; s.ex_dest = 5'd5;          step(s, 1'b1);

    // Load-use: one stall, then MEM forwarding; unused source does not stall
    step(lu, 1'b1);
    s = lu; s.ex_ins = INS_BUBBLE; s.mem_ins = INS_LW; s.mem_dest = 5'd3; step(s, 1'b1);
    s = lu; s.use_rt = 0;                          step(s, 1'b1);

    // DIV then MFHI held in ID until the result lands
    step(dv, 1'b1);
    repeat (7) step(mf, 1'b1);
    repeat (2) step(nop(), 1'b1);

    // Back-to-back DIV: second one launches from DONE
    step(dv, 1'b1);
    repeat (6) step(dv, 1'b1);
    repeat (8) step(nop(), 1'b1);

    // Asynchronous reset with the divider mid-count abandons the divide
    step(dv, 1'b1);
    step(mf, 1'b1);
    step(mf, 1'b0);
    step(mf, 1'b0);
    repeat (2) step(mf, 1'b1);

    // Stall counter saturation
    repeat (20) step(lu, 1'b1);
    step(nop(), 1'b1);

    // Random traffic with a narrow register range to provoke matches
    for (int i = 0; i < 1500; i++) begin
      s.valid    = 1'($urandom_range(0, 3) != 0);
      s.ins      = 6'($urandom_range(0, 8));
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.use_rs   = 1'($urandom_range(0, 1));
      s.use_rt   = 1'($urandom_range(0, 1));
      s.ex_ins   = 6'($urandom_range(0, 8));
      s.mem_ins  = 6'($urandom_range(0, 8));
      s.ex_dest  = 5'($urandom_range(0, 3));
      s.mem_dest = 5'($urandom_range(0, 3));
      step(s, 1'($urandom_range(0, 199) != 0));
    end
    step(nop(), 1'b1);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
